draw_cmd_decoder: RTL and testbench

Command-list consumer of the draw engine. It sits between the DRAWCMD command FIFO (fed over the register bus) and the pixel/AXI write unit. It pops 32-bit command words and decodes SETFRAME, SETDRAWAREA, SETFCOLOR, PATBLT, NOP and EODL. It holds the drawing state, and for each PATBLT it issues one clipped, absolute rectangle request to the writer.

---
 rtl/draw_pkg.sv | 30 +++
 rtl/draw_clip.sv | 66 ++++++
 rtl/draw_cmd_decoder.sv | 228 ++++++++++++++++++++++
 tb/tb_draw_cmd_decoder.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared opcodes, FSM state encoding and rectangle type for the draw command decoder.
package draw_pkg;

    localparam logic [7:0] OP_SETFRAME    = 8'h20;
    localparam logic [7:0] OP_SETDRAWAREA = 8'h21;
    localparam logic [7:0] OP_SETFCOLOR   = 8'h23;
    localparam logic [7:0] OP_PATBLT      = 8'h81;
    localparam logic [7:0] OP_EODL        = 8'h0F;
    localparam logic [7:0] OP_NOP         = 8'h00;

    localparam int unsigned RECT_CW = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP,
        ST_P1,
        ST_P2,
        ST_CLIP,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic [RECT_CW-1:0] x;
        logic [RECT_CW-1:0] y;
        logic [RECT_CW-1:0] w;
        logic [RECT_CW-1:0] h;
    } rect_t;

endpackage

// File: rtl/draw_clip.sv
// Combinational clip of an area-relative rectangle against the draw area and frame.
module draw_clip #(
    parameter int unsigned CW = 16
) (
    input  logic [CW-1:0] area_x_i,
    input  logic [CW-1:0] area_y_i,
    input  logic [CW-1:0] area_w_i,
    input  logic [CW-1:0] area_h_i,
    input  logic [CW-1:0] frame_w_i,
    input  logic [CW-1:0] frame_h_i,
    input  logic [CW-1:0] pos_x_i,
    input  logic [CW-1:0] pos_y_i,
    input  logic [CW-1:0] size_x_i,
    input  logic [CW-1:0] size_y_i,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic [CW-1:0] w_o,
    output logic [CW-1:0] h_o,
    output logic          empty_o
);

    // Two guard bits keep origin+pos+size from wrapping for any field values.
    localparam int unsigned XW = CW + 2;

    // Result packs {empty, origin, length}.
    function automatic logic [2*CW:0] clip_axis(
        input logic [CW-1:0] org,
        input logic [CW-1:0] len,
        input logic [CW-1:0] pos,
        input logic [CW-1:0] size,
        input logic [CW-1:0] lim
    );
        logic [XW-1:0] a;
        logic [XW-1:0] e;
        logic [XW-1:0] e_area;
        logic [XW-1:0] e_frame;
        logic [2*CW:0] r;
        a       = XW'(org) + XW'(pos);
        e       = a + XW'(size);
        e_area  = XW'(org) + XW'(len);
        e_frame = XW'(lim);
        if (e_area < e) e = e_area;
        if (e_frame < e) e = e_frame;
        r = '0;
        if (a >= e) begin
            r[2*CW] = 1'b1;
        end else begin
            r[2*CW-1:CW] = a[CW-1:0];
            r[CW-1:0]    = CW'(e - a);
        end
        return r;
    endfunction

    logic [2*CW:0] cx;
    logic [2*CW:0] cy;

    assign cx = clip_axis(area_x_i, area_w_i, pos_x_i, size_x_i, frame_w_i);
    assign cy = clip_axis(area_y_i, area_h_i, pos_y_i, size_y_i, frame_h_i);

    assign empty_o = cx[2*CW] | cy[2*CW];
    assign x_o     = cx[2*CW-1:CW];
    assign w_o     = cx[CW-1:0];
    assign y_o     = cy[2*CW-1:CW];
    assign h_o     = cy[CW-1:0];

endmodule

// File: rtl/draw_cmd_decoder.sv
// Draw command list decoder: pops DRAWCMD words, holds the drawing state and
// issues one clipped absolute rectangle request per PATBLT to the pixel writer.
module draw_cmd_decoder
    import draw_pkg::*;
#(
    parameter int unsigned CW   = 16,
    parameter int unsigned ADRW = 32
) (
    input  logic            ACLK,
    input  logic            ARST,
    input  logic            start,
    input  logic [31:0]     cmd_data,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    output logic            blt_valid,
    input  logic            blt_ready,
    output logic [CW-1:0]   blt_x,
    output logic [CW-1:0]   blt_y,
    output logic [CW-1:0]   blt_w,
    output logic [CW-1:0]   blt_h,
    output logic [23:0]     blt_color,
    output logic [ADRW-1:0] blt_vram,
    output logic [CW-1:0]   blt_stride,
    input  logic            wr_idle,
    output logic            busy,
    output logic            done,
    output logic            err
);

    state_t          state_q;
    logic [7:0]      op_q;
    logic [ADRW-1:0] vram_q;
    logic [CW-1:0]   frame_w_q;
    logic [CW-1:0]   frame_h_q;
    logic [CW-1:0]   area_x_q;
    logic [CW-1:0]   area_y_q;
    logic [CW-1:0]   area_w_q;
    logic [CW-1:0]   area_h_q;
    logic [23:0]     color_q;
    logic [CW-1:0]   pos_x_q;
    logic [CW-1:0]   pos_y_q;
    logic [CW-1:0]   size_x_q;
    logic [CW-1:0]   size_y_q;
    rect_t           blt_q;
    logic            blt_valid_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    logic [7:0]      cmd_op;
    logic [CW-1:0]   cmd_hi;
    logic [CW-1:0]   cmd_lo;
    logic [CW-1:0]   clip_x;
    logic [CW-1:0]   clip_y;
    logic [CW-1:0]   clip_w;
    logic [CW-1:0]   clip_h;
    logic            clip_empty;
    rect_t           clip_rect_d;

    assign cmd_op = cmd_data[31:24];
    assign cmd_hi = CW'(cmd_data[31:16]);
    assign cmd_lo = CW'(cmd_data[15:0]);

    draw_clip #(
        .CW (CW)
    ) u_clip (
        .area_x_i  (area_x_q),
        .area_y_i  (area_y_q),
        .area_w_i  (area_w_q),
        .area_h_i  (area_h_q),
        .frame_w_i (frame_w_q),
        .frame_h_i (frame_h_q),
        .pos_x_i   (pos_x_q),
        .pos_y_i   (pos_y_q),
        .size_x_i  (size_x_q),
        .size_y_i  (size_y_q),
        .x_o       (clip_x),
        .y_o       (clip_y),
        .w_o       (clip_w),
        .h_o       (clip_h),
        .empty_o   (clip_empty)
    );

    always_comb begin
        clip_rect_d   = '0;
        clip_rect_d.x = RECT_CW'(clip_x);
        clip_rect_d.y = RECT_CW'(clip_y);
        clip_rect_d.w = RECT_CW'(clip_w);
        clip_rect_d.h = RECT_CW'(clip_h);
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            vram_q      <= '0;
            frame_w_q   <= '0;
            frame_h_q   <= '0;
            area_x_q    <= '0;
            area_y_q    <= '0;
            area_w_q    <= '0;
            area_h_q    <= '0;
            color_q     <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            size_x_q    <= '0;
            size_y_q    <= '0;
            blt_q       <= '0;
            blt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_OP;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end
                end
                ST_OP: begin
                    if (cmd_valid) begin
                        op_q <= cmd_op;
                        case (cmd_op)
                            OP_SETFRAME, OP_SETDRAWAREA, OP_SETFCOLOR, OP_PATBLT:
                                state_q <= ST_P1;
                            OP_EODL: state_q <= ST_DRAIN;
                            OP_NOP:  state_q <= ST_OP;
                            default: begin
                                // Abort: leave the rest of the list in the FIFO.
                                err_q   <= 1'b1;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_P1: begin
                    if (cmd_valid) begin
                        case (op_q)
                            OP_SETFRAME: begin
                                vram_q  <= ADRW'(cmd_data);
                                state_q <= ST_P2;
                            end
                            OP_SETDRAWAREA: begin
                                area_x_q <= cmd_hi;
                                area_y_q <= cmd_lo;
                                state_q  <= ST_P2;
                            end
                            OP_SETFCOLOR: begin
                                color_q <= cmd_data[23:0];
                                state_q <= ST_OP;
                            end
                            OP_PATBLT: begin
                                pos_x_q <= cmd_hi;
                                pos_y_q <= cmd_lo;
                                state_q <= ST_P2;
                            end
                            default: state_q <= ST_OP;
                        endcase
                    end
                end
                ST_P2: begin
                    if (cmd_valid) begin
                        case (op_q)
                            OP_SETFRAME: begin
                                frame_w_q <= cmd_hi;
                                frame_h_q <= cmd_lo;
                                state_q   <= ST_OP;
                            end
                            OP_SETDRAWAREA: begin
                                area_w_q <= cmd_hi;
                                area_h_q <= cmd_lo;
                                state_q  <= ST_OP;
                            end
                            OP_PATBLT: begin
                                size_x_q <= cmd_hi;
                                size_y_q <= cmd_lo;
                                state_q  <= ST_CLIP;
                            end
                            default: state_q <= ST_OP;
                        endcase
                    end
                end
                ST_CLIP: begin
                    if (clip_empty) begin
                        state_q <= ST_OP;
                    end else begin
                        blt_q       <= clip_rect_d;
                        blt_valid_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (blt_ready) begin
                        blt_valid_q <= 1'b0;
                        state_q     <= ST_OP;
                    end
                end
                ST_DRAIN: begin
                    if (wr_idle) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == ST_OP) || (state_q == ST_P1) || (state_q == ST_P2);
    assign blt_valid  = blt_valid_q;
    assign blt_x      = CW'(blt_q.x);
    assign blt_y      = CW'(blt_q.y);
    assign blt_w      = CW'(blt_q.w);
    assign blt_h      = CW'(blt_q.h);
    assign blt_color  = color_q;
    assign blt_vram   = vram_q;
    assign blt_stride = frame_w_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_draw_cmd_decoder.sv
// Randomized and directed bench for draw_cmd_decoder against a list-level reference model.
module tb_draw_cmd_decoder;

    localparam int unsigned CW   = 16;
    localparam int unsigned ADRW = 32;

    logic            ACLK = 1'b0;
    logic            ARST = 1'b1;
    logic            start = 1'b0;
    logic [31:0]     cmd_data;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            blt_valid;
    logic            blt_ready;
    logic [CW-1:0]   blt_x, blt_y, blt_w, blt_h;
    logic [23:0]     blt_color;
    logic [ADRW-1:0] blt_vram;
    logic [CW-1:0]   blt_stride;
    logic            wr_idle;
    logic            busy, done, err;

    always #5 ACLK = ~ACLK;

    draw_cmd_decoder #(.CW(CW), .ADRW(ADRW)) dut (
        .ACLK(ACLK), .ARST(ARST), .start(start),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .blt_valid(blt_valid), .blt_ready(blt_ready),
        .blt_x(blt_x), .blt_y(blt_y), .blt_w(blt_w), .blt_h(blt_h),
        .blt_color(blt_color), .blt_vram(blt_vram), .blt_stride(blt_stride),
        .wr_idle(wr_idle), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        int          x, y, w, h, color;
        logic [31:0] vram;
        int          stride;
    } req_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] fifo[$];
    logic [31:0] lst[$];
    req_t        exp_q[$];

    int  gap_pct = 0, ready_pct = 100, ready_hold = 0;
    bit  wr_rand = 0;
    bit  fire = 0;
    int  done_cnt = 0, xfer_cnt = 0, xfer_base = 0, done_base = 0;
    bit  prev_stall = 0;
    logic [63:0] prev_geom, prev_attr, prev_stride;
    logic [63:0] last_geom = '0, last_attr = '0;

    // Reference model state: persists across lists, cleared by reset.
    logic [31:0] m_vram;
    int  m_fw, m_fh, m_ax, m_ay, m_aw, m_ah, m_col;
    bit  m_err;
    int  m_remain;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
        #2;
    endtask

    task automatic model_reset();
        m_vram = '0; m_fw = 0; m_fh = 0; m_ax = 0; m_ay = 0; m_aw = 0; m_ah = 0; m_col = 0;
    endtask

    task automatic expect_blt(input int px, input int py, input int sx, input int sy);
        int ax, ay, ex, ey;
        req_t r;
        ax = m_ax + px;
        ay = m_ay + py;
        ex = ax + sx;
        ey = ay + sy;
        if (m_ax + m_aw < ex) ex = m_ax + m_aw;
        if (m_fw < ex) ex = m_fw;
        if (m_ay + m_ah < ey) ey = m_ay + m_ah;
        if (m_fh < ey) ey = m_fh;
        if (ax < ex && ay < ey) begin
            r = '{ax, ay, ex - ax, ey - ay, m_col, m_vram, m_fw};
            exp_q.push_back(r);
        end
    endtask

    task automatic model_run();
        int i;
        logic [31:0] w, p1, p2;
        logic [7:0]  op;
        i = 0;
        m_err = 0;
        while (i < lst.size()) begin
            w  = lst[i];
            op = w[31:24];
            i++;
            if (op == 8'h0F) break;
            if (op == 8'h00) continue;
            if (op == 8'h20) begin
                m_vram = lst[i]; p2 = lst[i+1];
                m_fw = int'(p2[31:16]); m_fh = int'(p2[15:0]);
                i += 2;
            end else if (op == 8'h21) begin
                p1 = lst[i]; p2 = lst[i+1];
                m_ax = int'(p1[31:16]); m_ay = int'(p1[15:0]);
                m_aw = int'(p2[31:16]); m_ah = int'(p2[15:0]);
                i += 2;
            end else if (op == 8'h23) begin
                p1 = lst[i];
                m_col = int'(p1[23:0]);
                i += 1;
            end else if (op == 8'h81) begin
                p1 = lst[i]; p2 = lst[i+1];
                expect_blt(int'(p1[31:16]), int'(p1[15:0]), int'(p2[31:16]), int'(p2[15:0]));
                i += 2;
            end else begin
                m_err = 1;
                break;
            end
        end
        m_remain = lst.size() - i;
    endtask

    task automatic cmd_frame(input logic [31:0] vram, input int w, input int h);
        lst.push_back(32'h2000_0000); lst.push_back(vram); lst.push_back({16'(w), 16'(h)});
    endtask
    task automatic cmd_area(input int x, input int y, input int w, input int h);
        lst.push_back(32'h2100_0000); lst.push_back({16'(x), 16'(y)}); lst.push_back({16'(w), 16'(h)});
    endtask
    task automatic cmd_color(input logic [23:0] c);
        lst.push_back(32'h2300_0000); lst.push_back({8'h00, c});
    endtask
    task automatic cmd_blt(input int x, input int y, input int w, input int h);
        lst.push_back(32'h8100_0000); lst.push_back({16'(x), 16'(y)}); lst.push_back({16'(w), 16'(h)});
    endtask

    task automatic begin_list();
        model_run();
        foreach (lst[k]) fifo.push_back(lst[k]);
        lst.delete();
        done_base = done_cnt;
        xfer_base = xfer_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_list(input int limit);
        int n;
        n = 0;
        while (done_cnt == done_base && n < limit) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check_eq("done_once", 64'(done_cnt - done_base), 64'(1));
        check_eq("busy_after_done", 64'(busy), 64'(0));
        check_eq("err_after_done", 64'(err), 64'(m_err));
        check_eq("all_blt_issued", 64'(exp_q.size()), 64'(0));
        check_eq("fifo_left", 64'(fifo.size()), 64'(m_remain));
    endtask

    task automatic check_last(input string tag, input int x, input int y, input int w, input int h,
                              input logic [23:0] c);
        logic [23:0] got_c;
        got_c = last_attr[55:32];
        check_eq({tag, "_geom"}, last_geom, {16'(x), 16'(y), 16'(w), 16'(h)});
        check_eq({tag, "_color"}, 64'(got_c), 64'(c));
    endtask

    // FIFO / writer driver and request monitor.
    initial begin
        req_t e;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        blt_ready = 1'b0;
        wr_idle   = 1'b1;
        forever begin
            @(negedge ACLK);
            #1;
            if (fire) void'(fifo.pop_front());
            fire = 0;
            if (ready_hold > 0) begin
                blt_ready = 1'b0;
                ready_hold--;
            end else begin
                blt_ready = (int'($urandom_range(99)) < ready_pct);
            end
            if (wr_rand) wr_idle = ($urandom_range(3) != 0);
            if (fifo.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
                cmd_valid = 1'b1;
                cmd_data  = fifo[0];
            end else begin
                cmd_valid = 1'b0;
                cmd_data  = $urandom;
            end
            #2;
            fire = cmd_valid && cmd_ready && !ARST;
            if (prev_stall) begin
                check_eq("hold_valid", 64'(blt_valid), 64'(1));
                check_eq("hold_geom", {blt_x, blt_y, blt_w, blt_h}, prev_geom);
                check_eq("hold_attr", {8'h00, blt_color, blt_vram}, prev_attr);
                check_eq("hold_stride", 64'(blt_stride), prev_stride);
            end
            if (blt_valid && blt_ready && !ARST) begin
                xfer_cnt++;
                last_geom = {blt_x, blt_y, blt_w, blt_h};
                last_attr = {8'h00, blt_color, blt_vram};
                check_eq("blt_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("blt_geom", last_geom, {16'(e.x), 16'(e.y), 16'(e.w), 16'(e.h)});
                    check_eq("blt_attr", last_attr, {8'h00, 24'(e.color), e.vram});
                    check_eq("blt_stride", 64'(blt_stride), 64'(16'(e.stride)));
                end
            end
            prev_stall  = blt_valid && !blt_ready && !ARST;
            prev_geom   = {blt_x, blt_y, blt_w, blt_h};
            prev_attr   = {8'h00, blt_color, blt_vram};
            prev_stride = 64'(blt_stride);
            if (done) begin
                done_cnt++;
                check_eq("busy_at_done", 64'(busy), 64'(0));
            end
        end
    end

    initial begin
        int n, ncmd, r;
        model_reset();
        repeat (3) tick();
        ARST = 1'b0;
        tick();
        check_eq("rst_valid", 64'(blt_valid), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done_err", 64'({done, err}), 64'(0));
        check_eq("rst_ready", 64'(cmd_ready), 64'(0));
        check_eq("rst_geom", {blt_x, blt_y, blt_w, blt_h}, 64'(0));
        check_eq("rst_attr", {8'h00, blt_color, blt_vram}, 64'(0));
        check_eq("rst_stride", 64'(blt_stride), 64'(0));

        // Full-screen blit.
        cmd_frame(32'h2000_0000, 640, 480);
        cmd_area(0, 0, 640, 480);
        cmd_color(24'hFF0000);
        cmd_blt(0, 0, 640, 480);
        lst.push_back(32'h0F00_0000);
        begin_list();
        finish_list(500);
        check_last("t1", 0, 0, 640, 480, 24'hFF0000);
        check_eq("t1_vram", last_attr[31:0], 64'h2000_0000);
        check_eq("t1_count", 64'(xfer_cnt - xfer_base), 64'(1));

        // Centred blit, frame and area carried over.
        cmd_color(24'h00FF00);
        cmd_blt(160, 120, 320, 240);
        lst.push_back(32'h0F00_0000);
        begin_list();
        finish_list(500);
        check_last("t2", 160, 120, 320, 240, 24'h00FF00);

        // Area clip.
        cmd_area(160, 120, 320, 240);
        cmd_color(24'h0000FF);
        cmd_blt(0, 0, 640, 480);
        lst.push_back(32'h0F00_0000);
        begin_list();
        finish_list(500);
        check_last("t3", 160, 120, 320, 240, 24'h0000FF);

        // Edge clip followed by a fully clipped blit.
        cmd_area(0, 0, 640, 480);
        cmd_blt(480, 360, 320, 240);
        cmd_blt(700, 0, 10, 10);
        lst.push_back(32'h0F00_0000);
        begin_list();
        finish_list(500);
        check_last("t4", 480, 360, 160, 120, 24'h0000FF);
        check_eq("t4_count", 64'(xfer_cnt - xfer_base), 64'(1));

        // Backpressure, FIFO gaps and a slow writer drain.
        gap_pct = 50;
        wr_idle = 1'b0;
        cmd_color(24'h123456);
        cmd_blt(10, 20, 30, 40);
        cmd_blt(0, 0, 5, 5);
        lst.push_back(32'h0F00_0000);
        ready_hold = 50;
        begin_list();
        n = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0) && n < 1000) begin
            tick();
            n++;
        end
        check_eq("t5_drained", 64'(fifo.size() + exp_q.size()), 64'(0));
        repeat (20) tick();
        check_eq("t5_no_early_done", 64'(done_cnt - done_base), 64'(0));
        check_eq("t5_busy_drain", 64'(busy), 64'(1));
        wr_idle = 1'b1;
        finish_list(100);
        gap_pct = 0;

        // Unknown opcode aborts the list; next start clears err.
        lst.push_back(32'h5500_0000);
        cmd_blt(1, 1, 2, 2);
        lst.push_back(32'h0F00_0000);
        begin_list();
        finish_list(100);
        check_eq("t6_err_sticky", 64'(err), 64'(1));
        fifo.delete();
        lst.push_back(32'h0F00_0000);
        begin_list();
        check_eq("t6_err_cleared", 64'(err), 64'(0));
        finish_list(100);

        // Start coinciding with reset is ignored.
        ARST = 1'b1;
        start = 1'b1;
        tick();
        ARST = 1'b0;
        start = 1'b0;
        model_reset();
        tick();
        check_eq("rst_beats_start", 64'(busy), 64'(0));

        // Reset while a request is outstanding.
        ready_pct = 0;
        cmd_frame(32'h0000_1000, 64, 64);
        cmd_area(0, 0, 64, 64);
        cmd_blt(1, 2, 3, 4);
        lst.push_back(32'h0F00_0000);
        begin_list();
        n = 0;
        while (!blt_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq("t6b_issue", 64'(blt_valid), 64'(1));
        done_base = done_cnt;
        ARST = 1'b1;
        tick();
        ARST = 1'b0;
        check_eq("t6b_valid_drop", 64'(blt_valid), 64'(0));
        check_eq("t6b_busy_drop", 64'(busy), 64'(0));
        repeat (5) tick();
        check_eq("t6b_no_done", 64'(done_cnt - done_base), 64'(0));
        fifo.delete();
        exp_q.delete();
        model_reset();
        ready_pct = 100;

        // Randomized lists with persistent drawing state.
        gap_pct = 30;
        ready_pct = 70;
        wr_rand = 1;
        cmd_frame($urandom, int'($urandom_range(800)), int'($urandom_range(800)));
        for (int l = 0; l < 40; l++) begin
            ncmd = int'($urandom_range(6, 1));
            for (int c = 0; c < ncmd; c++) begin
                r = int'($urandom_range(9));
                if (r == 0)
                    cmd_frame($urandom, int'($urandom_range(800)), int'($urandom_range(800)));
                else if (r <= 2)
                    cmd_area(int'($urandom_range(700)), int'($urandom_range(700)),
                             int'($urandom_range(700)), int'($urandom_range(700)));
                else if (r == 3)
                    cmd_color(24'($urandom));
                else if (r == 8)
                    lst.push_back(32'h0000_0000);
                else
                    cmd_blt(int'($urandom_range(800)), int'($urandom_range(800)),
                            int'($urandom_range(800)), int'($urandom_range(800)));
            end
            lst.push_back(32'h0F00_0000);
            begin_list();
            finish_list(3000);
        end
        wr_rand = 0;
        wr_idle = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
